// File: rtl/manchester_encoder.sv
// manchester_encoder
//   Frame-level Manchester transmitter. Each frame is the 16-bit preamble
//   0xAAD5 followed by FRAME_SIZE payload bytes, MSB first, IEEE 802.3
//   polarity (bit 1 -> low/high, bit 0 -> high/low), then GAP_HALFBITS
//   low half-bits of idle.
// Ports
//   aclk, areset         clock, synchronous active-high reset
//   s_tdata/s_tvalid/
//   s_tready             payload byte stream into a one-byte holding register
//   line_out             registered Manchester line
//   tx_busy              high whenever a frame or its gap is in progress
//   frame_done           pulse during the final half-bit cycle of the frame
//   tx_underrun          pulse when a byte boundary finds the hold empty
module manchester_encoder #(
    parameter int FRAME_SIZE      = 4,
    parameter int HALF_BIT_CYCLES = 1,
    parameter int GAP_HALFBITS    = 8
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [7:0] s_tdata,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic       line_out,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       tx_underrun
);

    localparam int              TW        = $clog2(HALF_BIT_CYCLES + 1);
    localparam logic [TW-1:0]   TICK_LAST = TW'(HALF_BIT_CYCLES - 1);
    localparam logic [15:0]     PRE_WORD  = 16'hAAD5;
    localparam logic [3:0]      LAST_BYTE = 4'(FRAME_SIZE - 1);
    localparam logic [3:0]      FRAME_CNT = 4'(FRAME_SIZE);
    localparam logic [5:0]      GAP_LAST  = 6'(GAP_HALFBITS - 1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tick, tick_n;
    logic [5:0]    hb_cnt, hb_n;        // index of the half-bit now on line_out
    logic [3:0]    byte_cnt, byte_n;
    logic [3:0]    accepted_cnt, acc_n;
    logic [7:0]    hold_data, hold_data_n;
    logic          hold_valid, hold_valid_n;
    logic [7:0]    shift_data, shift_n;
    logic          line_n;

    logic accept, half_end, pre_last, byte_last, gap_last, last_byte;

    // Half-bit value: first half is the inverted bit, second half the bit.
    function automatic logic pre_half(input logic [5:0] idx);
        logic b;
        b = PRE_WORD[4'd15 - idx[4:1]];
        return idx[0] ? b : ~b;
    endfunction

    function automatic logic data_half(input logic [7:0] d, input logic [5:0] idx);
        logic b;
        b = d[3'd7 - idx[3:1]];
        return idx[0] ? b : ~b;
    endfunction

    assign s_tready  = !hold_valid && !areset && state != GAP &&
                       (state == IDLE || accepted_cnt < FRAME_CNT);
    assign accept    = s_tvalid && s_tready;
    assign half_end  = (tick == TICK_LAST);
    assign pre_last  = (hb_cnt == 6'd31);
    assign byte_last = (hb_cnt == 6'd15);
    assign gap_last  = (hb_cnt == GAP_LAST);
    assign last_byte = (byte_cnt == LAST_BYTE);

    assign tx_busy     = (state != IDLE);
    assign frame_done  = !areset && state == DATA && half_end && byte_last && last_byte;
    assign tx_underrun = !areset && half_end && !hold_valid &&
                         ((state == PREAMBLE && pre_last) ||
                          (state == DATA && byte_last && !last_byte));

    always_comb begin
        state_n      = state;
        tick_n       = tick;
        hb_n         = hb_cnt;
        byte_n       = byte_cnt;
        acc_n        = accepted_cnt;
        hold_data_n  = hold_data;
        hold_valid_n = hold_valid;
        shift_n      = shift_data;
        line_n       = line_out;

        if (accept) begin
            hold_data_n  = s_tdata;
            hold_valid_n = 1'b1;
            acc_n        = accepted_cnt + 4'd1;
        end

        if (state != IDLE)
            tick_n = half_end ? '0 : tick + TW'(1);

        case (state)
            IDLE: begin
                line_n = 1'b0;
                tick_n = '0;
                hb_n   = '0;
                byte_n = '0;
                if (accept) begin
                    state_n = PREAMBLE;
                    line_n  = pre_half(6'd0);
                end
            end
            PREAMBLE: begin
                if (half_end) begin
                    if (!pre_last) begin
                        hb_n   = hb_cnt + 6'd1;
                        line_n = pre_half(hb_cnt + 6'd1);
                    end else if (hold_valid) begin
                        state_n      = DATA;
                        shift_n      = hold_data;
                        hold_valid_n = 1'b0;
                        hb_n         = '0;
                        byte_n       = '0;
                        line_n       = data_half(hold_data, 6'd0);
                    end else begin
                        state_n = GAP;
                        hb_n    = '0;
                        line_n  = 1'b0;
                    end
                end
            end
            DATA: begin
                if (half_end) begin
                    if (!byte_last) begin
                        hb_n   = hb_cnt + 6'd1;
                        line_n = data_half(shift_data, hb_cnt + 6'd1);
                    end else if (last_byte) begin
                        state_n = GAP;
                        hb_n    = '0;
                        line_n  = 1'b0;
                    end else if (hold_valid) begin
                        shift_n      = hold_data;
                        hold_valid_n = 1'b0;
                        byte_n       = byte_cnt + 4'd1;
                        hb_n         = '0;
                        line_n       = data_half(hold_data, 6'd0);
                    end else begin
                        // A byte accepted on this very edge is too late for
                        // the abandoned frame; drop it so IDLE starts clean.
                        state_n      = GAP;
                        hold_valid_n = 1'b0;
                        hb_n         = '0;
                        line_n       = 1'b0;
                    end
                end
            end
            GAP: begin
                line_n = 1'b0;
                if (half_end) begin
                    if (gap_last) begin
                        state_n = IDLE;
                        hb_n    = '0;
                        acc_n   = '0;
                    end else begin
                        hb_n = hb_cnt + 6'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state        <= IDLE;
            tick         <= '0;
            hb_cnt       <= '0;
            byte_cnt     <= '0;
            accepted_cnt <= '0;
            hold_data    <= '0;
            hold_valid   <= 1'b0;
            shift_data   <= '0;
            line_out     <= 1'b0;
        end else begin
            state        <= state_n;
            tick         <= tick_n;
            hb_cnt       <= hb_n;
            byte_cnt     <= byte_n;
            accepted_cnt <= acc_n;
            hold_data    <= hold_data_n;
            hold_valid   <= hold_valid_n;
            shift_data   <= shift_n;
            line_out     <= line_n;
        end
    end

endmodule

// File: tb/tb_manchester_encoder.sv
// Bench for manchester_encoder: directed and randomized stream stimulus,
// every cycle compared against a timeline model of the frame format.
module tb_manchester_encoder;

    localparam int FS  = 4;
    localparam int H   = 3;
    localparam int GAP = 5;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic [7:0] s_tdata = 8'h00;
    logic       s_tvalid = 1'b0;
    logic       s_tready, line_out, tx_busy, frame_done, tx_underrun;

    manchester_encoder #(.FRAME_SIZE(FS), .HALF_BIT_CYCLES(H), .GAP_HALFBITS(GAP)) dut (
        .aclk(aclk), .areset(areset), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tready(s_tready), .line_out(line_out), .tx_busy(tx_busy),
        .frame_done(frame_done), .tx_underrun(tx_underrun)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;

    // Model: mode 0 idle, 1 frame on the line, 2 trailing gap.
    int          cyc = 0;
    int          mode = 0;
    int          n0 = 0;       // handshake cycle that opened the frame
    int          acc = 0;      // bytes accepted for this frame
    int          gend = 0;     // last gap cycle
    logic [7:0]  fb [0:15];
    logic [15:0] pre_word = 16'hAAD5;
    logic        acc_now = 1'b0;
    int          done_dur = -1;
    int          n_done = 0;
    int          n_unr = 0;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance it.
    task automatic tick(input logic rst, input logic v, input logic [7:0] d);
        logic e_line, e_busy, e_rdy, e_done, e_unr, bitv;
        int t, h, ph, k, j;
        @(negedge aclk);
        areset = rst; s_tvalid = v; s_tdata = d;
        #1;
        cyc++;
        e_line = 1'b0; e_busy = (mode != 0); e_rdy = 1'b0; e_done = 1'b0; e_unr = 1'b0;
        if (mode == 0) begin
            e_rdy = 1'b1;
        end else if (mode == 1) begin
            t = cyc - n0; h = (t - 1) / H; ph = (t - 1) % H;
            if (h < 32) begin
                bitv = pre_word[15 - h / 2];
            end else begin
                k = (h - 32) / 16; j = (h - 32) % 16;
                bitv  = fb[k][7 - j / 2];
                e_rdy = (acc == k + 1) && (acc < FS);
                if (j == 15 && ph == H - 1) begin
                    if (k == FS - 1)      e_done = 1'b1;
                    else if (acc <= k + 1) e_unr = 1'b1;
                end
            end
            e_line = (h % 2 == 1) ? bitv : ~bitv;
        end
        if (rst) begin e_rdy = 1'b0; e_done = 1'b0; e_unr = 1'b0; end

        check("line_out", line_out, e_line);
        check("tx_busy", tx_busy, e_busy);
        check("s_tready", s_tready, e_rdy);
        check("frame_done", frame_done, e_done);
        check("tx_underrun", tx_underrun, e_unr);
        if (frame_done === 1'b1) begin n_done++; done_dur = cyc - n0; end
        if (tx_underrun === 1'b1) n_unr++;

        acc_now = v && e_rdy;
        if (rst) mode = 0;
        else case (mode)
            0: if (acc_now) begin mode = 1; n0 = cyc; acc = 1; fb[0] = d; end
            1: begin
                if (acc_now) begin fb[acc] = d; acc++; end
                if (e_done || e_unr) begin mode = 2; gend = cyc + GAP * H; end
            end
            default: if (cyc == gend) mode = 0;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] d);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            tick(1'b0, 1'b1, d);
            got = acc_now;
        end
        check("send_byte_accepted", got, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && mode != 0; i++) tick(1'b0, 1'b0, 8'h00);
        check_int("wait_idle_mode", mode, 0);
    endtask

    initial begin
        int u0, d0, base, dens;
        logic [7:0] nb;
        logic v, r;

        areset = 1'b1;
        repeat (2) @(posedge aclk);
        // Reset state over several cycles.
        repeat (3) tick(1'b1, 1'b1, 8'h55);
        repeat (2) tick(1'b0, 1'b0, 8'h00);

        // Single frame, bytes back-to-back, plus frame length.
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        wait_idle();
        check_int("frame_duration", done_dur, (32 + 16 * FS) * H);
        tick(1'b0, 1'b0, 8'h00);

        // Backpressure: valid held high for two frames.
        nb = 8'h10;
        for (int i = 0; i < 2 * ((32 + 16 * FS + GAP) * H + 1) + 4; i++) begin
            tick(1'b0, 1'b1, nb);
            if (acc_now) nb = nb + 8'h01;
        end
        check_int("backpressure_bytes", int'(nb) - 16, 2 * FS + 1);
        for (int i = 0; i < 4 && mode != 0; i++) send_byte(nb);
        wait_idle();

        // Underrun after a single byte.
        u0 = n_unr; d0 = n_done;
        send_byte(8'hA5);
        wait_idle();
        check_int("underrun_pulses", n_unr - u0, 1);
        check_int("underrun_no_done", n_done - d0, 0);

        // Reset during the second data byte, then a clean frame.
        send_byte(8'h11); send_byte(8'h22);
        base = n0;
        while (cyc - base < (32 + 16 + 5) * H) tick(1'b0, 1'b0, 8'h00);
        u0 = n_unr; d0 = n_done;
        tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        check_int("reset_no_pulse", (n_unr - u0) + (n_done - d0), 0);
        send_byte(8'hC3); send_byte(8'h3C); send_byte(8'hFF); send_byte(8'h00);
        wait_idle();

        // Randomized traffic with varying offer density and rare resets.
        for (int seg = 0; seg < 20; seg++) begin
            dens = $urandom_range(0, 5);
            for (int i = 0; i < 250; i++) begin
                v = ($urandom_range(0, (1 << dens) - 1) == 0);
                r = ($urandom_range(0, 999) == 0);
                tick(r, v, 8'($urandom_range(0, 255)));
            end
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
